i2s_adc_deserializer: RTL and testbench
=======================================

Name: i2s_adc_deserializer

Overview:
- Receive side of the codec serial audio link; its counterpart is the DAC serializer driving dacdat.
- Deserializes the WM8731 ADC stream (adcdat, with codec-mastered bclk/adclrck) into stereo sample frames in the system clk domain.
- Presents frames on a valid/ready source port for the pitch/DSP path (e.g. microphone input to the theremin).
- Codec is clock master; this block samples only and drives nothing toward the codec.

Parameters:
DATA_W, 24, bits per channel word captured, MSB first (legal 16..32)
I2S_MODE, 1, 1 = I2S (MSB one bclk after lrck edge), 0 = left-justified (MSB on first bclk after lrck edge)

Ports:
clk  in  1  system clock, all logic on rising edge (>= 8x bclk)
reset  in  1  asynchronous, active-high reset
coe_bclk  in  1  codec bit clock, asynchronous to clk
coe_adclrck  in  1  codec ADC LR clock, low = left slot, high = right slot
coe_adcdat  in  1  codec ADC serial data
out_left  out  DATA_W  left sample, two's complement
out_right  out  DATA_W  right sample, two's complement
out_valid  out  1  frame available
out_ready  in  1  sink accepts frame when out_valid & out_ready
overrun  out  1  sticky: completed frame overwrote an unaccepted frame
slot_err  out  1  sticky: lrck toggled before DATA_W bits were received
err_clr  in  1  clears overrun and slot_err

Behaviour:
- Reset: all outputs 0, shift register 0, bit counter 0, state SYNC.
- Input capture: coe_bclk, coe_adclrck and coe_adcdat each pass a 2-FF synchronizer plus one history FF.
  - bclk_rise = synced bclk 0->1; lrck_edge = synced lrck change.
  - adcdat and lrck are taken from the same synchronizer stage, so they are mutually aligned with bclk_rise.
- All bit activity is qualified by bclk_rise. Between rises the block is idle.
- State machine:
  - SYNC: ignore all data until a falling lrck edge (start of left slot). Then go to DELAY if I2S_MODE=1, else SHIFT; channel=left, count=0.
  - DELAY: the first bclk_rise is discarded; go to SHIFT.
  - SHIFT: on each bclk_rise, shreg <= {shreg[DATA_W-2:0], adcdat} and count++. When count reaches DATA_W, go to WAIT.
    - Left slot: shreg -> left_hold.
    - Right slot: frame complete.
  - WAIT: ignore bclk_rise until lrck_edge. Then channel = new lrck level, count=0, go to DELAY/SHIFT per I2S_MODE.
- Short slot:
  - An lrck_edge while in SHIFT with count < DATA_W sets slot_err; the partial word is discarded.
  - The new slot starts normally from that edge.
  - If the discarded word was the left word, the following right word completes no frame; the block returns to waiting for the next left slot.
  - If the discarded word was the right word, no frame is emitted.
- Wrong-polarity edge (lrck rising while expecting a left slot, i.e. a right slot appearing without a valid left): treated as a right slot with no valid left; no frame is emitted.
- Frame completion (cycle after last right bit shifted):
  - out_left <= left_hold, out_right <= shreg, out_valid <= 1.
  - Latency from the bclk_rise of the last right-slot bit (as seen after synchronization) to out_valid high: 1 clk.
- Handshake:
  - out_valid drops the cycle after out_valid & out_ready.
  - out_left/out_right are stable while out_valid=1 and not accepted.
  - Frame completes while out_valid=1 and out_ready=0: data is overwritten with the new frame, out_valid stays 1, overrun <= 1.
  - Completion in the same cycle as acceptance: the new frame loads, out_valid stays 1, no overrun.
- Sticky flags: err_clr clears both flags. If err_clr and a set event occur in the same cycle, set wins.
- Reset mid-frame: immediate asynchronous return to the reset state; capture restarts from SYNC, so the first output frame is always complete and channel-aligned.
- Extra bclks beyond DATA_W in a slot (e.g. 32-bit slots with DATA_W=24) are ignored in WAIT.

Test Plan:
- I2S_MODE=1, DATA_W=24, bclk=3.072 MHz, clk=50 MHz, send L=0x123456, R=0xABCDEF -> out_valid once with out_left=0x123456, out_right=0xABCDEF; overrun=0, slot_err=0.
- Reset released mid right slot, then 3 full frames (L=0x000001/0x7FFFFF/0x800000, R=0x00FFFF...) -> exactly 3 frames, none garbled, first frame = first full L/R pair.
- out_ready held 0 across 2 frames, then pulsed -> overrun=1, accepted data equals the second frame; err_clr pulse -> overrun=0.
- lrck toggles after 10 bits of the left slot -> slot_err=1, no frame for that period; next full period yields a correct frame.
- I2S_MODE=0, DATA_W=16, 32-bit slots, L=0x8001, R=0x7FFE -> out_left=0x8001, out_right=0x7FFE; trailing 16 bits ignored.
- out_ready tied 1, continuous 48 kHz stream of 100 frames with incrementing values -> 100 accepted frames in order, out_valid high 1 clk each, flags stay 0.

Source files
------------

// File: rtl/i2s_adc_deserializer.sv
// WM8731 ADC stream deserializer: oversamples the codec-mastered bclk/adclrck/adcdat
// in the clk domain and emits stereo frames on a valid/ready source port.
module i2s_adc_deserializer #(
  parameter int DATA_W   = 24,
  parameter int I2S_MODE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coe_bclk,
  input  logic              coe_adclrck,
  input  logic              coe_adcdat,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              slot_err,
  input  logic              err_clr
);

  localparam int               CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {ST_SYNC, ST_DELAY, ST_SHIFT, ST_WAIT} state_t;
  localparam state_t ST_START = (I2S_MODE != 0) ? ST_DELAY : ST_SHIFT;

  // [1] is the synchronized sample, [2] its history; lrck and data share stage [1]
  logic [2:0] bclk_sr, lrck_sr, dat_sr;
  logic       bclk_rise, lrck_edge, lrck, adcdat;

  assign bclk_rise = bclk_sr[1] & ~bclk_sr[2];
  assign lrck_edge = lrck_sr[1] ^ lrck_sr[2];
  assign lrck      = lrck_sr[1];
  assign adcdat    = dat_sr[1];

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [DATA_W-1:0]  left_hold_q, left_hold_d;
  logic               channel_q, channel_d;
  logic               left_valid_q, left_valid_d;
  logic               load_frame, slot_err_set;

  // NOTE: always_comb uses blocking assignments, and every target gets a default
  // first so no path leaves a value unassigned (which would infer a latch).
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shreg_d      = shreg_q;
    left_hold_d  = left_hold_q;
    channel_d    = channel_q;
    left_valid_d = left_valid_q;
    load_frame   = 1'b0;
    slot_err_set = 1'b0;

    if (state_q == ST_SYNC) begin
      if (lrck_edge && !lrck) begin
        state_d      = ST_START;
        channel_d    = 1'b0;
        count_d      = '0;
        left_valid_d = 1'b0;
      end
    end else if (lrck_edge) begin
      // A new slot always restarts capture; an unfinished word is dropped.
      if (state_q == ST_SHIFT) slot_err_set = 1'b1;
      state_d   = ST_START;
      channel_d = lrck;
      count_d   = '0;
      if (!lrck) left_valid_d = 1'b0;
    end else if (bclk_rise) begin
      case (state_q)
        ST_DELAY: state_d = ST_SHIFT;
        ST_SHIFT: begin
          shreg_d = {shreg_q[DATA_W-2:0], adcdat};
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d = ST_WAIT;
            if (!channel_q) begin
              left_hold_d  = shreg_d;
              left_valid_d = 1'b1;
            end else if (left_valid_q) begin
              // Right word without a preceding complete left word emits nothing.
              load_frame   = 1'b1;
              left_valid_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, and every register
  // here has an asynchronous reset value so capture always restarts cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sr      <= '0;
      lrck_sr      <= '0;
      dat_sr       <= '0;
      state_q      <= ST_SYNC;
      count_q      <= '0;
      shreg_q      <= '0;
      left_hold_q  <= '0;
      channel_q    <= 1'b0;
      left_valid_q <= 1'b0;
      out_left     <= '0;
      out_right    <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
      slot_err     <= 1'b0;
    end else begin
      bclk_sr      <= {bclk_sr[1:0], coe_bclk};
      lrck_sr      <= {lrck_sr[1:0], coe_adclrck};
      dat_sr       <= {dat_sr[1:0], coe_adcdat};
      state_q      <= state_d;
      count_q      <= count_d;
      shreg_q      <= shreg_d;
      left_hold_q  <= left_hold_d;
      channel_q    <= channel_d;
      left_valid_q <= left_valid_d;

      if (load_frame) begin
        out_left  <= left_hold_q;
        out_right <= shreg_d;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Set beats clear when both happen in the same cycle.
      overrun  <= (load_frame & out_valid & ~out_ready) | (overrun & ~err_clr);
      slot_err <= slot_err_set | (slot_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_i2s_adc_deserializer.sv
// Directed bench: drives codec-style I2S / left-justified frames into a 24-bit I2S
// instance and a 16-bit left-justified instance, checking captured frames and flags.
module tb_i2s_adc_deserializer;

  localparam int HALF = 40;  // bclk half period; clk period is 10

  logic clk = 1'b0;
  logic reset;
  logic bclk, lrck, dat, out_ready, err_clr;
  logic [23:0] out_left, out_right;
  logic out_valid, overrun, slot_err;

  logic bclk16, lrck16, dat16;
  logic rdy16 = 1'b1;
  logic clr16 = 1'b0;
  logic [15:0] l16, r16;
  logic v16, ovr16, serr16;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cycles = 0;
  logic [47:0] got_q[$];
  logic [31:0] got16_q[$];

  always #5 clk = ~clk;

  i2s_adc_deserializer #(.DATA_W(24), .I2S_MODE(1)) dut (
    .clk(clk), .reset(reset), .coe_bclk(bclk), .coe_adclrck(lrck), .coe_adcdat(dat),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .slot_err(slot_err), .err_clr(err_clr)
  );

  i2s_adc_deserializer #(.DATA_W(16), .I2S_MODE(0)) dut16 (
    .clk(clk), .reset(reset), .coe_bclk(bclk16), .coe_adclrck(lrck16), .coe_adcdat(dat16),
    .out_left(l16), .out_right(r16), .out_valid(v16),
    .out_ready(rdy16), .overrun(ovr16), .slot_err(serr16), .err_clr(clr16)
  );

  always @(negedge clk) begin
    if (out_valid) begin
      valid_cycles++;
      if (out_ready) got_q.push_back({out_left, out_right});
    end
    if (v16 && rdy16) got16_q.push_back({l16, r16});
  end

  task automatic drive_bit(input bit sel, input logic lr, input logic d);
    if (!sel) begin bclk = 1'b0; lrck = lr; dat = d; end
    else begin bclk16 = 1'b0; lrck16 = lr; dat16 = d; end
    #(HALF);
    if (!sel) bclk = 1'b1; else bclk16 = 1'b1;
    #(HALF);
  endtask

  // One slot of slot_bits bclks; bits outside the word carry the fill value.
  task automatic drive_slot(input bit sel, input logic lr, input logic [31:0] word,
                            input int dw, input bit i2s, input int slot_bits, input logic fill);
    for (int k = 0; k < slot_bits; k++) begin
      int p;
      logic d;
      p = i2s ? k - 1 : k;
      d = fill;
      if (p >= 0 && p < dw) d = word[dw-1-p];
      drive_bit(sel, lr, d);
    end
  endtask

  task automatic send_frame(input bit sel, input logic [31:0] l, input logic [31:0] r,
                            input int dw, input bit i2s, input int slot_bits, input logic fill);
    drive_slot(sel, 1'b0, l, dw, i2s, slot_bits, fill);
    drive_slot(sel, 1'b1, r, dw, i2s, slot_bits, fill);
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_left !== 24'h0) begin n_fail++; $display("FAIL reset_left got=%h exp=0", out_left); end
    n_checks++; if (out_right !== 24'h0) begin n_fail++; $display("FAIL reset_right got=%h exp=0", out_right); end
    n_checks++; if ({out_valid, overrun, slot_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {out_valid, overrun, slot_err}); end
    reset = 1'b0;
    settle();
  endtask

  task automatic test_basic();
    logic [47:0] exp;
    got_q.delete();
    send_frame(1'b0, 32'h123456, 32'hABCDEF, 24, 1'b1, 32, 1'b1);
    settle();
    exp = {24'h123456, 24'hABCDEF};
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL basic_count got=%0d exp=1", got_q.size()); end
    n_checks++; if (got_q.size() == 0 || got_q[0] !== exp) begin n_fail++; $display("FAIL basic_data got=%h exp=%h", got_q.size() ? got_q[0] : 48'h0, exp); end
    n_checks++; if ({overrun, slot_err} !== 2'b00) begin n_fail++; $display("FAIL basic_flags got=%b exp=00", {overrun, slot_err}); end
  endtask

  task automatic test_reset_mid_frame();
    logic [47:0] exp [3];
    exp[0] = {24'h000001, 24'h00FFFF};
    exp[1] = {24'h7FFFFF, 24'h555555};
    exp[2] = {24'h800000, 24'hAAAAAA};
    #1 reset = 1'b1;
    #1;
    n_checks++; if (out_left !== 24'h0) begin n_fail++; $display("FAIL async_reset_left got=%h exp=0", out_left); end
    got_q.delete();
    fork
      send_frame(1'b0, 32'h0F0F0F, 32'hF0F0F0, 24, 1'b1, 32, 1'b0);
      begin #(2 * HALF * (32 + 10)); reset = 1'b0; end
    join
    send_frame(1'b0, 32'h000001, 32'h00FFFF, 24, 1'b1, 32, 1'b0);
    send_frame(1'b0, 32'h7FFFFF, 32'h555555, 24, 1'b1, 32, 1'b0);
    send_frame(1'b0, 32'h800000, 32'hAAAAAA, 24, 1'b1, 32, 1'b0);
    settle();
    n_checks++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL midreset_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_q.size() <= i || got_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL midreset_frame%0d got=%h exp=%h", i, got_q.size() > i ? got_q[i] : 48'h0, exp[i]);
      end
    end
  endtask

  task automatic test_overrun();
    got_q.delete();
    @(posedge clk); #1 out_ready = 1'b0;
    send_frame(1'b0, 32'h111111, 32'h222222, 24, 1'b1, 32, 1'b0);
    send_frame(1'b0, 32'h333333, 32'h444444, 24, 1'b1, 32, 1'b0);
    settle();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got=%b exp=1", out_valid); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    n_checks++; if ({out_left, out_right} !== {24'h333333, 24'h444444}) begin n_fail++; $display("FAIL ovr_hold got=%h exp=333333444444", {out_left, out_right}); end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    settle();
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL ovr_accept_count got=%0d exp=1", got_q.size()); end
    n_checks++; if (got_q.size() == 0 || got_q[0] !== {24'h333333, 24'h444444}) begin n_fail++; $display("FAIL ovr_accept_data got=%h exp=333333444444", got_q.size() ? got_q[0] : 48'h0); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_drop got=%b exp=0", out_valid); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    out_ready = 1'b1;
  endtask

  task automatic test_short_slot();
    got_q.delete();
    // Delay bit plus 10 data bits, then lrck flips to the right slot.
    drive_slot(1'b0, 1'b0, 32'h5A5A5A, 24, 1'b1, 11, 1'b0);
    drive_slot(1'b0, 1'b1, 32'h0C0C0C, 24, 1'b1, 32, 1'b0);
    settle();
    n_checks++; if (slot_err !== 1'b1) begin n_fail++; $display("FAIL short_slot_err got=%b exp=1", slot_err); end
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL short_no_frame got=%0d exp=0", got_q.size()); end
    send_frame(1'b0, 32'hFEDCBA, 32'h010203, 24, 1'b1, 32, 1'b0);
    settle();
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== {24'hFEDCBA, 24'h010203}) begin n_fail++; $display("FAIL short_recover got_n=%0d got=%h exp=fedcba010203", got_q.size(), got_q.size() ? got_q[0] : 48'h0); end
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    n_checks++; if (slot_err !== 1'b0) begin n_fail++; $display("FAIL short_clear got=%b exp=0", slot_err); end
  endtask

  task automatic test_left_justified();
    got16_q.delete();
    send_frame(1'b1, 32'h8001, 32'h7FFE, 16, 1'b0, 32, 1'b1);
    settle();
    n_checks++; if (got16_q.size() !== 1) begin n_fail++; $display("FAIL lj_count got=%0d exp=1", got16_q.size()); end
    n_checks++; if (got16_q.size() == 0 || got16_q[0] !== {16'h8001, 16'h7FFE}) begin n_fail++; $display("FAIL lj_data got=%h exp=80017ffe", got16_q.size() ? got16_q[0] : 32'h0); end
    n_checks++; if ({ovr16, serr16} !== 2'b00) begin n_fail++; $display("FAIL lj_flags got=%b exp=00", {ovr16, serr16}); end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    valid_cycles = 0;
    for (int i = 0; i < 100; i++)
      send_frame(1'b0, 32'(24'(i * 5 + 1)), 32'(24'(24'h800000 + i)), 24, 1'b1, 26, 1'b0);
    settle();
    n_checks++; if (got_q.size() !== 100) begin n_fail++; $display("FAIL stream_count got=%0d exp=100", got_q.size()); end
    for (int i = 0; i < 100; i++) begin
      logic [47:0] exp;
      exp = {24'(i * 5 + 1), 24'(24'h800000 + i)};
      n_checks++;
      if (got_q.size() <= i || got_q[i] !== exp) begin
        n_fail++; $display("FAIL stream_frame%0d got=%h exp=%h", i, got_q.size() > i ? got_q[i] : 48'h0, exp);
      end
    end
    n_checks++; if (valid_cycles !== 100) begin n_fail++; $display("FAIL stream_valid_cycles got=%0d exp=100", valid_cycles); end
    n_checks++; if ({overrun, slot_err} !== 2'b00) begin n_fail++; $display("FAIL stream_flags got=%b exp=00", {overrun, slot_err}); end
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1; err_clr = 1'b0;
    bclk = 1'b0; lrck = 1'b1; dat = 1'b0;
    bclk16 = 1'b0; lrck16 = 1'b1; dat16 = 1'b0;
    test_reset();
    test_basic();
    test_reset_mid_frame();
    test_overrun();
    test_short_slot();
    test_left_justified();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
